// File: rtl/iob_eth_mii_rx_pkg.sv
// Shared definitions for the MII receive framer: FSM states, nibble codes,
// CRC-32 constants and the layout of a FIFO entry.
package iob_eth_mii_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_LO,
    ST_HI,
    ST_DROP
  } rx_state_t;

  localparam logic [3:0] PRE_NIB = 4'h5;
  localparam logic [3:0] SFD_NIB = 4'hD;

  localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

  localparam int unsigned ENTRY_W  = 10;
  localparam int unsigned BYTE_LSB = 0;
  localparam int unsigned LAST_BIT = 8;
  localparam int unsigned ERR_BIT  = 9;

  function automatic logic [31:0] bit_rev32(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // LSB-first CRC-32 update; the register therefore holds the reflected form
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc ^ {24'h0, b};
    for (int unsigned i = 0; i < 8; i++)
      c = c[0] ? ((c >> 1) ^ bit_rev32(CRC_POLY)) : (c >> 1);
    return c;
  endfunction

endpackage

// File: rtl/iob_eth_mii_rx_framer_if.sv
// Byte-stream handshake from the framer FIFO head toward the ethernet core.
interface iob_eth_mii_rx_framer_if;
  logic [7:0] data_o;
  logic       valid_o;
  logic       last_o;
  logic       err_o;
  logic       ready_i;

  modport master (output data_o, output valid_o, output last_o, output err_o, input ready_i);
  modport slave  (input data_o, input valid_o, input last_o, input err_o, output ready_i);
endinterface

// File: rtl/iob_eth_mii_rx_fifo.sv
// Synchronous first-word-fall-through FIFO of framer entries; push and pop
// in the same cycle are allowed even when full.
module iob_eth_mii_rx_fifo
  import iob_eth_mii_rx_pkg::*;
#(
  parameter int unsigned AW = 4
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               push_i,
  input  logic [ENTRY_W-1:0] push_data_i,
  input  logic               pop_i,
  output logic [ENTRY_W-1:0] pop_data_o,
  output logic               full_o,
  output logic               empty_o
);
  localparam int unsigned DEPTH = 2 ** AW;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr_q;
  logic [AW-1:0]      rd_ptr_q;
  logic [AW:0]        cnt_q;
  logic               do_push;
  logic               do_pop;

  assign full_o     = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o    = (cnt_q == '0);
  assign do_pop     = pop_i & ~empty_o;
  assign do_push    = push_i & (~full_o | do_pop);
  assign pop_data_o = mem[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (!do_push && do_pop) cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/iob_eth_mii_rx_framer.sv
// MII RX framer: strips preamble/SFD, packs nibbles into bytes, tags frame end
// and errors, and buffers bytes in a FWFT FIFO. Optional FCS check: IOB_ETH_MII_RX_FCS_CHECK_EN.
module iob_eth_mii_rx_framer
  import iob_eth_mii_rx_pkg::*;
#(
  parameter int unsigned FIFO_AW       = 4,
  parameter int unsigned MIN_PRE_NIB   = 2,
  parameter int unsigned MAX_FRAME_LEN = 1522
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    mii_rx_dv_i,
  input  logic                    mii_rx_er_i,
  input  logic [3:0]              mii_rx_data_i,
  iob_eth_mii_rx_framer_if.master rx_if,
  output logic                    busy_o,
  output logic [15:0]             frame_cnt_o,
  output logic [15:0]             err_cnt_o
);
  localparam int unsigned PC_W = $clog2(MIN_PRE_NIB + 2);
  localparam int unsigned BC_W = $clog2(MAX_FRAME_LEN + 2);

  rx_state_t          state_q, state_d;
  logic [PC_W-1:0]    pre_cnt_q, pre_cnt_d;
  logic [3:0]         lo_q, lo_d;
  logic [BC_W-1:0]    byte_cnt_q, byte_cnt_d;
  logic               err_flag_q, err_flag_d;
  logic               stage_vld_q, stage_vld_d;
  logic [7:0]         stage_byte_q, stage_byte_d;
  logic               pend_q, pend_d;
  logic               pend_err_q, pend_err_d;
  logic [15:0]        frame_cnt_q, err_cnt_q;

  logic               push, push_last, push_err;
  logic [ENTRY_W-1:0] push_entry, head_entry;
  logic               fifo_full, fifo_empty, pop, can_push;
  logic               eof, eof_err, frame_err, inc_frame, inc_err;
  logic [7:0]         new_byte;

`ifdef IOB_ETH_MII_RX_FCS_CHECK_EN
  logic [31:0]        crc_q, crc_d;
  // register runs LSB-first, so the good-frame residue appears bit-reversed
  assign frame_err = err_flag_q | (crc_q != bit_rev32(CRC_RESIDUE));
`else
  assign frame_err = err_flag_q;
`endif

  assign pop      = ~fifo_empty & rx_if.ready_i;
  assign can_push = ~fifo_full | pop;
  assign new_byte = {mii_rx_data_i, lo_q};

  always_comb begin
    state_d      = state_q;
    pre_cnt_d    = pre_cnt_q;
    lo_d         = lo_q;
    byte_cnt_d   = byte_cnt_q;
    err_flag_d   = err_flag_q;
    stage_vld_d  = stage_vld_q;
    stage_byte_d = stage_byte_q;
    pend_d       = pend_q;
    pend_err_d   = pend_err_q;
    push         = 1'b0;
    push_last    = 1'b0;
    push_err     = 1'b0;
    eof          = 1'b0;
    eof_err      = 1'b0;
    inc_frame    = 1'b0;
    inc_err      = 1'b0;
`ifdef IOB_ETH_MII_RX_FCS_CHECK_EN
    crc_d        = crc_q;
`endif
    // a pending termination only exists while no frame is being received
    if (pend_q && can_push) begin
      push        = 1'b1;
      push_last   = 1'b1;
      push_err    = pend_err_q;
      stage_vld_d = 1'b0;
      pend_d      = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (mii_rx_dv_i) begin
          if (mii_rx_data_i == PRE_NIB && !pend_q) begin
            state_d   = ST_PRE;
            pre_cnt_d = PC_W'(1);
          end else begin
            state_d = ST_DROP;
          end
        end
      end
      ST_PRE: begin
        if (!mii_rx_dv_i) begin
          state_d = ST_IDLE;
        end else if (mii_rx_data_i == PRE_NIB) begin
          if (pre_cnt_q != '1) pre_cnt_d = pre_cnt_q + 1'b1;
        end else if (mii_rx_data_i == SFD_NIB && pre_cnt_q >= PC_W'(MIN_PRE_NIB)) begin
          state_d    = ST_LO;
          byte_cnt_d = '0;
          err_flag_d = 1'b0;
`ifdef IOB_ETH_MII_RX_FCS_CHECK_EN
          crc_d      = CRC_INIT;
`endif
        end else begin
          state_d = ST_DROP;
        end
      end
      ST_LO: begin
        if (mii_rx_dv_i) begin
          lo_d       = mii_rx_data_i;
          err_flag_d = err_flag_q | mii_rx_er_i;
          state_d    = ST_HI;
        end else begin
          eof     = 1'b1;
          eof_err = frame_err;
          state_d = ST_IDLE;
        end
      end
      ST_HI: begin
        if (mii_rx_dv_i) begin
          // overflow and over-length both truncate: keep the staged byte as the last one
          if (byte_cnt_q == BC_W'(MAX_FRAME_LEN) || (stage_vld_q && !can_push)) begin
            state_d = ST_DROP;
            if (stage_vld_q) begin
              pend_d     = 1'b1;
              pend_err_d = 1'b1;
            end else begin
              inc_err = 1'b1;
            end
          end else begin
            err_flag_d   = err_flag_q | mii_rx_er_i;
            push         = stage_vld_q;
            stage_byte_d = new_byte;
            stage_vld_d  = 1'b1;
            byte_cnt_d   = byte_cnt_q + 1'b1;
`ifdef IOB_ETH_MII_RX_FCS_CHECK_EN
            crc_d        = crc32_byte(crc_q, new_byte);
`endif
            state_d      = ST_LO;
          end
        end else begin
          eof     = 1'b1;
          eof_err = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (!mii_rx_dv_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (eof) begin
      if (!stage_vld_q) begin
        inc_err = 1'b1;
      end else if (can_push) begin
        push        = 1'b1;
        push_last   = 1'b1;
        push_err    = eof_err;
        stage_vld_d = 1'b0;
      end else begin
        pend_d     = 1'b1;
        pend_err_d = eof_err;
      end
    end

    if (push && push_last) begin
      if (push_err) inc_err   = 1'b1;
      else          inc_frame = 1'b1;
    end
  end

  always_comb begin
    push_entry                     = '0;
    push_entry[BYTE_LSB +: 8]      = stage_byte_q;
    push_entry[LAST_BIT]           = push_last;
    push_entry[ERR_BIT]            = push_err;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_IDLE;
      pre_cnt_q    <= '0;
      lo_q         <= '0;
      byte_cnt_q   <= '0;
      err_flag_q   <= 1'b0;
      stage_vld_q  <= 1'b0;
      stage_byte_q <= '0;
      pend_q       <= 1'b0;
      pend_err_q   <= 1'b0;
      frame_cnt_q  <= '0;
      err_cnt_q    <= '0;
`ifdef IOB_ETH_MII_RX_FCS_CHECK_EN
      crc_q        <= CRC_INIT;
`endif
    end else begin
      state_q      <= state_d;
      pre_cnt_q    <= pre_cnt_d;
      lo_q         <= lo_d;
      byte_cnt_q   <= byte_cnt_d;
      err_flag_q   <= err_flag_d;
      stage_vld_q  <= stage_vld_d;
      stage_byte_q <= stage_byte_d;
      pend_q       <= pend_d;
      pend_err_q   <= pend_err_d;
      if (inc_frame && frame_cnt_q != '1) frame_cnt_q <= frame_cnt_q + 1'b1;
      if (inc_err && err_cnt_q != '1)     err_cnt_q   <= err_cnt_q + 1'b1;
`ifdef IOB_ETH_MII_RX_FCS_CHECK_EN
      crc_q        <= crc_d;
`endif
    end
  end

  iob_eth_mii_rx_fifo #(
    .AW(FIFO_AW)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .push_i     (push),
    .push_data_i(push_entry),
    .pop_i      (pop),
    .pop_data_o (head_entry),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign rx_if.valid_o = ~fifo_empty;
  assign rx_if.data_o  = fifo_empty ? '0 : head_entry[BYTE_LSB +: 8];
  assign rx_if.last_o  = ~fifo_empty & head_entry[LAST_BIT];
  assign rx_if.err_o   = ~fifo_empty & head_entry[ERR_BIT];
  assign busy_o        = (state_q != ST_IDLE);
  assign frame_cnt_o   = frame_cnt_q;
  assign err_cnt_o     = err_cnt_q;

endmodule

// File: tb/tb_iob_eth_mii_rx_framer.sv
// Directed bench for iob_eth_mii_rx_framer with a scoreboard of expected FIFO entries.
module tb_iob_eth_mii_rx_framer;
  localparam int unsigned MAX_LEN = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dv;
  logic        er;
  logic [3:0]  nib;
  logic        busy;
  logic [15:0] frame_cnt;
  logic [15:0] err_cnt;

  int          checks = 0;
  int          errors = 0;
  int          exp_frames = 0;
  int          exp_errs = 0;
  logic [9:0]  sb[$];
  logic [7:0]  frame[$];

  always #5 clk = ~clk;

  iob_eth_mii_rx_framer_if rx_if ();

  iob_eth_mii_rx_framer #(
    .FIFO_AW      (4),
    .MIN_PRE_NIB  (2),
    .MAX_FRAME_LEN(MAX_LEN)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .mii_rx_dv_i  (dv),
    .mii_rx_er_i  (er),
    .mii_rx_data_i(nib),
    .rx_if        (rx_if),
    .busy_o       (busy),
    .frame_cnt_o  (frame_cnt),
    .err_cnt_o    (err_cnt)
  );

  function automatic logic [31:0] crc_upd(input logic [31:0] c_in, input logic [7:0] b);
    logic [31:0] c;
    c = c_in ^ {24'h0, b};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

`ifdef IOB_ETH_MII_RX_FCS_CHECK_EN
  function automatic bit fcs_bad();
    logic [31:0] c;
    int n;
    c = 32'hFFFFFFFF;
    n = frame.size();
    if (n < 4) return 1'b1;
    for (int i = 0; i < n - 4; i++) c = crc_upd(c, frame[i]);
    return (~c) != {frame[n-1], frame[n-2], frame[n-3], frame[n-4]};
  endfunction
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic e, input logic [3:0] n);
    @(posedge clk);
    #1;
    dv  = v;
    er  = e;
    nib = n;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 4'h0);
  endtask

  task automatic send_frame(input int npre, input int er_byte, input bit dribble, input bit model);
    int n;
    int nkeep;
    bit e;
    n = frame.size();
    e = 1'b0;
    if (model) begin
      nkeep = (n > MAX_LEN) ? MAX_LEN : n;
      e = dribble || (er_byte >= 0) || (n > MAX_LEN);
`ifdef IOB_ETH_MII_RX_FCS_CHECK_EN
      e = e || fcs_bad();
`endif
      if (nkeep == 0) begin
        exp_errs++;
      end else begin
        for (int i = 0; i < nkeep; i++)
          sb.push_back({(i == nkeep - 1) && e, i == nkeep - 1, frame[i]});
        if (e) exp_errs++;
        else   exp_frames++;
      end
    end
    for (int i = 0; i < npre; i++) drive(1'b1, 1'b0, 4'h5);
    drive(1'b1, 1'b0, 4'hD);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, i == er_byte, frame[i][3:0]);
      drive(1'b1, i == er_byte, frame[i][7:4]);
    end
    if (dribble) drive(1'b1, 1'b0, 4'hA);
    idle(4);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !rx_if.valid_o) break;
    end
    chk(tag, sb.size(), 0);
  endtask

  task automatic check_counts(input string tag);
    chk({tag, "_frame_cnt"}, frame_cnt, exp_frames);
    chk({tag, "_err_cnt"}, err_cnt, exp_errs);
  endtask

  always @(negedge clk) begin : monitor
    logic [9:0] e;
    if (rst_n && rx_if.valid_o && rx_if.ready_i) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_output: observed byte=%02h expected no output", rx_if.data_o);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checks++;
        assert ({rx_if.err_o & e[8], rx_if.last_o, rx_if.data_o} === {e[9] & e[8], e[8], e[7:0]}) else begin
          errors++;
          $error("FAIL stream_entry: observed err/last/data=%0b/%0b/%02h expected %0b/%0b/%02h",
                 rx_if.err_o, rx_if.last_o, rx_if.data_o, e[9], e[8], e[7:0]);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] c;
    rst_n = 1'b0;
    dv = 1'b0;
    er = 1'b0;
    nib = 4'h0;
    rx_if.ready_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", rx_if.valid_o, 0);
    chk("rst_data", rx_if.data_o, 0);
    chk("rst_last_err", {rx_if.last_o, rx_if.err_o}, 0);
    chk("rst_busy", busy, 0);
    check_counts("rst");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // good frame, long preamble
    frame = '{8'h12, 8'h34, 8'h56};
    send_frame(7, -1, 1'b0, 1'b1);
    wait_drain("good_drain");
    check_counts("good");

    // rx_er during byte 2 of 4
    frame = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    send_frame(7, 1, 1'b0, 1'b1);
    wait_drain("rxer_drain");
    check_counts("rxer");

    // minimum preamble accepted
    frame = '{8'h5A, 8'hA5, 8'h0F};
    send_frame(2, -1, 1'b0, 1'b1);
    wait_drain("minpre_drain");
    check_counts("minpre");

    // single preamble nibble: dropped
    frame = '{8'h77, 8'h88};
    send_frame(1, -1, 1'b0, 1'b0);
    @(negedge clk);
    chk("shortpre_valid", rx_if.valid_o, 0);
    chk("shortpre_busy", busy, 0);
    check_counts("shortpre");

    // dribble nibble
    frame = '{8'h01, 8'h02, 8'h03};
    send_frame(7, -1, 1'b1, 1'b1);
    wait_drain("dribble_drain");
    check_counts("dribble");

    // empty frame
    frame.delete();
    send_frame(7, -1, 1'b0, 1'b1);
    wait_drain("empty_drain");
    check_counts("empty");

    // 60 bytes + FCS = exactly the length limit; then one bit flipped
    frame.delete();
    c = 32'hFFFFFFFF;
    for (int i = 0; i < 60; i++) begin
      frame.push_back(8'(i * 37 + 5));
      c = crc_upd(c, frame[i]);
    end
    c = ~c;
    for (int i = 0; i < 4; i++) frame.push_back(c[8*i +: 8]);
    send_frame(7, -1, 1'b0, 1'b1);
    wait_drain("fcs_good_drain");
    check_counts("fcs_good");
    frame[10] = frame[10] ^ 8'h04;
    send_frame(7, -1, 1'b0, 1'b1);
    wait_drain("fcs_bad_drain");
    check_counts("fcs_bad");

    // over the length limit: truncated at MAX_LEN with err
    frame.delete();
    for (int i = 0; i < 66; i++) frame.push_back(8'(8'hC0 + i));
    send_frame(7, -1, 1'b0, 1'b1);
    wait_drain("maxlen_drain");
    check_counts("maxlen");

    // FIFO overflow with the consumer stalled, second frame during termination
    rx_if.ready_i = 1'b0;
    frame.delete();
    for (int i = 0; i < 20; i++) frame.push_back(8'(8'h40 + i));
    for (int i = 0; i < 16; i++) sb.push_back({2'b00, frame[i]});
    sb.push_back({2'b11, frame[16]});
    exp_errs++;
    send_frame(7, -1, 1'b0, 1'b0);
    frame = '{8'hE0, 8'hE1, 8'hE2, 8'hE3, 8'hE4};
    send_frame(7, -1, 1'b0, 1'b0);
    @(negedge clk);
    chk("ovf_held", sb.size(), 17);
    chk("ovf_head", rx_if.data_o, 8'h40);
    @(posedge clk);
    #1 rx_if.ready_i = 1'b1;
    wait_drain("ovf_drain");
    idle(4);
    @(negedge clk);
    chk("ovf_idle_valid", rx_if.valid_o, 0);
    check_counts("ovf");

    // reset mid-frame with bytes buffered
    rx_if.ready_i = 1'b0;
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 4'h5);
    drive(1'b1, 1'b0, 4'hD);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 4'(i));
      drive(1'b1, 1'b0, 4'h9);
    end
    @(negedge clk);
    chk("midrst_pre_valid", rx_if.valid_o, 1);
    chk("midrst_pre_busy", busy, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    dv = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_frames = 0;
    exp_errs = 0;
    @(negedge clk);
    chk("midrst_valid", rx_if.valid_o, 0);
    chk("midrst_busy", busy, 0);
    check_counts("midrst");
    rx_if.ready_i = 1'b1;

    frame = '{8'h9A, 8'hBC, 8'hDE};
    send_frame(7, -1, 1'b0, 1'b1);
    wait_drain("postrst_drain");
    check_counts("postrst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
